sonar_array_ctrl: RTL
=====================

// Module: sonar_array_ctrl
// PURPOSE
//  Multi-channel HC-SR04-style sonar sequencer. Fires N_CH sonars one at a time in round-robin
//  (no crosstalk) and measures each echo pulse width in clk cycles. Keeps a per-channel result
//  bank with valid/overflow/no-echo status for the robot's distance map.
//  Supports single-sweep and continuous modes, per-channel enable, timeout and abort.
// PARAMETERS
//  N_CH           4        number of sonar channels (1..8)
//  CNT_W          20       echo-width counter / distance width
//  TRIG_LOW_CYC   150      cycles trigger held low before pulse
//  TRIG_HIGH_CYC  600      trigger high width (12 us @ 50 MHz)
//  ECHO_WAIT_MAX  1500000  max cycles waiting for echo rise before no_echo (30 ms)
//  GUARD_CYC      500000   dead time after each ping before next channel (10 ms)
// PORTS
//  clk          in   1            system clock (CLOCK_50)
//  reset        in   1            asynchronous, active-high
//  start        in   1            pulse: begin a sweep (ignored while busy)
//  continuous   in   1            1: restart sweep automatically after sweep_done
//  abort        in   1            synchronous: stop sweep, return to IDLE
//  ch_enable    in   N_CH         channels included in sweep, latched at sweep start
//  echo         in   N_CH         raw echo inputs (asynchronous)
//  trigger      out  N_CH         trigger outputs, one-hot or zero
//  distance     out  N_CH*CNT_W   result bank, channel i at [i*CNT_W +: CNT_W]
//  valid        out  N_CH         channel holds a good measurement
//  overflow     out  N_CH         last ping of channel saturated the counter
//  no_echo      out  N_CH         last ping of channel timed out waiting for echo
//  busy         out  1            FSM not in IDLE
//  sweep_done   out  1            one-cycle pulse at end of each sweep
// BEHAVIOUR
//  - Reset: state IDLE; trigger=0, distance=0, valid=0, overflow=0, no_echo=0, busy=0,
//    sweep_done=0, cur_ch=0, counter=0, sync flops=0.
//  - echo passes through a 2-flop synchronizer per channel; only the active channel is used.
//  - States: IDLE, TRIG_LOW, TRIG_HIGH, WAIT_ECHO, COUNT, GUARD. Counter clears on every
//    state entry.
//  - IDLE: on start with ch_enable!=0: latch enables, cur_ch=lowest enabled, -> TRIG_LOW.
//    start with ch_enable==0: ignored, stays IDLE.
//  - TRIG_LOW: trigger=0 for TRIG_LOW_CYC cycles -> TRIG_HIGH.
//  - TRIG_HIGH: trigger[cur_ch]=1 exactly TRIG_HIGH_CYC cycles -> WAIT_ECHO.
//  - WAIT_ECHO: on sync echo high -> COUNT. Counter reaching ECHO_WAIT_MAX: no_echo[ch]=1,
//    valid[ch]=0, distance[ch] unchanged -> GUARD.
//  - COUNT: counter +1 per cycle sync echo high. On sync echo low: distance[ch]=counter
//    (= echo-high cycles), valid=1, overflow=0, no_echo=0 -> GUARD. Counter at 2^CNT_W-1 with
//    echo still high: distance=all ones, overflow=1, valid=0 -> GUARD.
//  - GUARD: counts only while sync echo low (waits out stuck/overflowed echo); after
//    GUARD_CYC low cycles: next enabled channel above cur_ch -> TRIG_LOW; none left: sweep_done=1
//    for one cycle, then continuous ? (relatch ch_enable, lowest enabled, TRIG_LOW) : IDLE.
//    Continuous restart with relatched ch_enable==0 -> IDLE.
//  - Result regs of a channel update only at its own ping end; others hold.
//  - abort (any state): next cycle IDLE, trigger=0, results/flags held, no sweep_done.
//    abort beats start in same cycle.
//  - reset mid-ping: trigger drops immediately (async), all results cleared.
//  - Outputs registered; trigger has no combinational path from inputs.
// TESTING  (sim params: CNT_W=8, TRIG_LOW_CYC=4, TRIG_HIGH_CYC=10, ECHO_WAIT_MAX=50, GUARD_CYC=8)
//  1 ch_enable=4'b0101, start, ch0 echo high 37 cyc, ch2 high 120 cyc -> trigger[0] then [2] each
//    high 10 cyc; distance0=37, distance2=120, valid=0101, one sweep_done, busy falls.
//  2 ch_enable=0001, echo held low -> no_echo[0]=1 after 50 wait cycles, valid[0]=0, sweep_done.
//  3 ch_enable=0001, echo high 300 cyc -> distance0=255, overflow[0]=1; guard starts after echo falls.
//  4 continuous=1, ch_enable=0011 -> trigger sequence 0,1,0,1...; sweep_done every sweep;
//    clear continuous -> IDLE after current sweep.
//  5 abort during TRIG_HIGH of ch1 -> trigger=0 next cycle, IDLE, earlier ch0 result intact.
//  6 reset asserted during COUNT -> trigger=0 and all outputs zero without clock edge.

Source files
------------

// File: rtl/sonar_array_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sonar_array_ctrl
//
// Round-robin sequencer for N_CH HC-SR04-style ultrasonic rangers. Only one
// sonar is pinged at a time so echoes from one transducer cannot be mistaken
// for another's. For every ping the controller holds the trigger low, pulses
// it high, waits for the echo to rise, measures the echo-high width in clk
// cycles and then sits out a guard interval before moving on. Each channel
// owns a result slot (distance + valid/overflow/no_echo) that changes only
// when that channel's own ping completes.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high
//   start       pulse: begin a sweep (ignored while busy)
//   continuous  1: restart the sweep automatically after sweep_done
//   abort       synchronous: stop the sweep and return to idle
//   ch_enable   channels included in a sweep, latched at sweep start
//   echo        raw echo inputs (asynchronous to clk)
//   trigger     trigger outputs, one-hot or all zero
//   distance    result bank, channel i at [i*CNT_W +: CNT_W]
//   valid       channel holds a good measurement
//   overflow    last ping of the channel saturated the width counter
//   no_echo     last ping of the channel timed out waiting for the echo
//   busy        sequencer is not idle
//   sweep_done  one-cycle pulse at the end of each sweep
// -----------------------------------------------------------------------------
module sonar_array_ctrl #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 20,
    parameter int TRIG_LOW_CYC  = 150,
    parameter int TRIG_HIGH_CYC = 600,
    parameter int ECHO_WAIT_MAX = 1500000,
    parameter int GUARD_CYC     = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    input  logic [N_CH-1:0]       ch_enable,
    input  logic [N_CH-1:0]       echo,
    output logic [N_CH-1:0]       trigger,
    output logic [N_CH*CNT_W-1:0] distance,
    output logic [N_CH-1:0]       valid,
    output logic [N_CH-1:0]       overflow,
    output logic [N_CH-1:0]       no_echo,
    output logic                  busy,
    output logic                  sweep_done
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // One shared timer serves every state, so it must hold the longest
    // interval as well as a full echo-width count.
    localparam int T_TRIG  = (TRIG_LOW_CYC > TRIG_HIGH_CYC) ? TRIG_LOW_CYC : TRIG_HIGH_CYC;
    localparam int T_WAIT  = (ECHO_WAIT_MAX > GUARD_CYC) ? ECHO_WAIT_MAX : GUARD_CYC;
    localparam int T_MAX   = (T_TRIG > T_WAIT) ? T_TRIG : T_WAIT;
    localparam int T_BITS  = $clog2(T_MAX + 1);
    localparam int TMR_W   = (T_BITS > CNT_W) ? T_BITS : CNT_W;

    localparam logic [TMR_W-1:0] TRIG_LOW_LAST  = TMR_W'(TRIG_LOW_CYC - 1);
    localparam logic [TMR_W-1:0] TRIG_HIGH_LAST = TMR_W'(TRIG_HIGH_CYC - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST      = TMR_W'(ECHO_WAIT_MAX - 1);
    localparam logic [TMR_W-1:0] GUARD_LAST     = TMR_W'(GUARD_CYC - 1);
    // The first echo-high cycle is consumed in WAIT_ECHO, so inside COUNT the
    // number of high cycles seen so far is counter + 1. Saturation happens
    // when that already equals all ones and the echo is still high.
    localparam logic [TMR_W-1:0] OVF_AT         = TMR_W'((2 ** CNT_W) - 2);
    localparam logic [TMR_W-1:0] TMR_ONE        = TMR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_LOW,
        S_TRIG_HIGH,
        S_WAIT_ECHO,
        S_COUNT,
        S_GUARD
    } state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] idx;
    } ch_pick_t;

    state_t                       state;
    logic [TMR_W-1:0]             counter;
    logic [CH_W-1:0]              cur_ch;
    logic [N_CH-1:0]              en_q;
    logic [N_CH-1:0][CNT_W-1:0]   dist_q;
    logic [N_CH-1:0]              sync1;
    logic [N_CH-1:0]              sync2;
    logic                         echo_s;
    ch_pick_t                     next_pick;
    ch_pick_t                     first_pick;

    // Lowest set bit of m at or above index lo.
    function automatic ch_pick_t pick_from(input logic [N_CH-1:0] m, input int lo);
        ch_pick_t p;
        p = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) begin
                p.found = 1'b1;
                p.idx   = CH_W'(i);
            end
        end
        return p;
    endfunction

    assign next_pick  = pick_from(en_q, int'(cur_ch) + 1);
    assign first_pick = pick_from(ch_enable, 0);
    assign echo_s     = sync2[cur_ch];
    assign distance   = dist_q;

    // Two-flop synchronizer per channel; the echoes are asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= echo;
            sync2 <= sync1;
        end
    end

    // NOTE: state and outputs are updated with non-blocking assignments so
    // every branch below sees the values from the start of the cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            counter    <= '0;
            cur_ch     <= '0;
            en_q       <= '0;
            trigger    <= '0;
            // NOTE: the result bank is a handful of flops, not a RAM, so it
            // can and must clear on reset along with the flags.
            dist_q     <= '0;
            valid      <= '0;
            overflow   <= '0;
            no_echo    <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;

            if (abort) begin
                // Abort wins over everything, including start and the
                // end-of-sweep pulse; results are left untouched.
                state   <= S_IDLE;
                counter <= '0;
                trigger <= '0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && first_pick.found) begin
                            en_q    <= ch_enable;
                            cur_ch  <= first_pick.idx;
                            counter <= '0;
                            busy    <= 1'b1;
                            state   <= S_TRIG_LOW;
                        end
                    end

                    S_TRIG_LOW: begin
                        if (counter == TRIG_LOW_LAST) begin
                            counter <= '0;
                            trigger <= N_CH'(1) << cur_ch;
                            state   <= S_TRIG_HIGH;
                        end else begin
                            counter <= counter + TMR_ONE;
                        end
                    end

                    S_TRIG_HIGH: begin
                        if (counter == TRIG_HIGH_LAST) begin
                            counter <= '0;
                            trigger <= '0;
                            state   <= S_WAIT_ECHO;
                        end else begin
                            counter <= counter + TMR_ONE;
                        end
                    end

                    S_WAIT_ECHO: begin
                        if (echo_s) begin
                            counter <= '0;
                            state   <= S_COUNT;
                        end else if (counter == WAIT_LAST) begin
                            no_echo[cur_ch]  <= 1'b1;
                            valid[cur_ch]    <= 1'b0;
                            overflow[cur_ch] <= 1'b0;
                            counter          <= '0;
                            state            <= S_GUARD;
                        end else begin
                            counter <= counter + TMR_ONE;
                        end
                    end

                    S_COUNT: begin
                        if (!echo_s) begin
                            dist_q[cur_ch]   <= CNT_W'(counter + TMR_ONE);
                            valid[cur_ch]    <= 1'b1;
                            overflow[cur_ch] <= 1'b0;
                            no_echo[cur_ch]  <= 1'b0;
                            counter          <= '0;
                            state            <= S_GUARD;
                        end else if (counter == OVF_AT) begin
                            dist_q[cur_ch]   <= {CNT_W{1'b1}};
                            overflow[cur_ch] <= 1'b1;
                            valid[cur_ch]    <= 1'b0;
                            no_echo[cur_ch]  <= 1'b0;
                            counter          <= '0;
                            state            <= S_GUARD;
                        end else begin
                            counter <= counter + TMR_ONE;
                        end
                    end

                    S_GUARD: begin
                        // Time only accrues while the echo is low, so a stuck
                        // or saturated echo is waited out before the next ping.
                        if (!echo_s) begin
                            if (counter == GUARD_LAST) begin
                                counter <= '0;
                                if (next_pick.found) begin
                                    cur_ch <= next_pick.idx;
                                    state  <= S_TRIG_LOW;
                                end else begin
                                    sweep_done <= 1'b1;
                                    if (continuous && first_pick.found) begin
                                        en_q   <= ch_enable;
                                        cur_ch <= first_pick.idx;
                                        state  <= S_TRIG_LOW;
                                    end else begin
                                        busy  <= 1'b0;
                                        state <= S_IDLE;
                                    end
                                end
                            end else begin
                                counter <= counter + TMR_ONE;
                            end
                        end
                    end

                    default: begin
                        state   <= S_IDLE;
                        counter <= '0;
                        trigger <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
